// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program-counter register and next-PC datapath for the fetch stage. It holds
// the PC and steps it by 1 or 2, or redirects it to a register target
// (X[SP] or R[rb]). For the reset vector M[0] and the interrupt vector M[1]
// it runs a two-cycle read of the synchronous instruction memory.
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   S_Target     target select: 0 M[0], 1 M[1], 2 X[SP], 3 R[rb]
//   E_Pc         update the PC this cycle (0 holds)
//   E_Imm        increment by 2 instead of 1 (used only when load=1)
//   load         1: increment, 0: load target
//   stall        pipeline stall, freezes everything except the pending interrupt
//   intr         level interrupt request
//   mem_data     instruction memory read data (one cycle after mem_addr)
//   sp_data      X[SP] value (popped return address)
//   rb_data      R[rb] value
//   pc           current PC (registered)
//   mem_addr     instruction memory address
//   vec_rd       high while a vector read is issued
//   fetch_valid  high when mem_addr=pc is a real fetch
//   intr_ack     one-cycle pulse after an interrupt is accepted
//   ret_addr     return address captured at interrupt accept

module pc_sequencer #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        S_Target,
   input  logic              E_Pc,
   input  logic              E_Imm,
   input  logic              load,
   input  logic              stall,
   input  logic              intr,
   input  logic [ADDR_W-1:0] mem_data,
   input  logic [ADDR_W-1:0] sp_data,
   input  logic [ADDR_W-1:0] rb_data,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              vec_rd,
   output logic              fetch_valid,
   output logic              intr_ack,
   output logic [ADDR_W-1:0] ret_addr
);

   typedef enum logic [1:0] {
      RST_VEC  = 2'd0,
      VEC_WAIT = 2'd1,
      RUN      = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;
   logic              vec_sel;
   logic              intr_pend;
   logic [ADDR_W-1:0] next_pc;
   logic              update_en;
   logic              mem_redirect;
   logic              accept;

   // Next-PC datapath and the decisions taken in RUN. A memory redirect
   // (target M[0]/M[1]) beats a pending interrupt; the interrupt simply waits
   // for the next eligible RUN cycle.
   always_comb begin
      next_pc = pc;
      if (load) begin
         next_pc = pc + (E_Imm ? ADDR_W'(2) : ADDR_W'(1));
      end else if (S_Target == 2'd2) begin
         next_pc = sp_data;
      end else if (S_Target == 2'd3) begin
         next_pc = rb_data;
      end
      update_en    = (state == RUN) && !stall && E_Pc;
      mem_redirect = update_en && !load && !S_Target[1];
      accept       = update_en && !mem_redirect && intr_pend;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RST_VEC;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. The vector states always advance: the memory read
   // completes regardless of stall.
   always_comb begin
      state_next = state;
      case (state)
         RST_VEC:  state_next = VEC_WAIT;
         VEC_WAIT: state_next = RUN;
         RUN: begin
            if (mem_redirect || accept) begin
               state_next = RST_VEC;
            end
         end
         default:  state_next = RST_VEC;
      endcase
   end

   // Output logic. Reset forces the vector-read view of M[0] immediately so
   // an abort mid-fetch or mid-RUN is visible in the same cycle.
   always_comb begin
      mem_addr    = pc;
      vec_rd      = 1'b0;
      fetch_valid = 1'b0;
      case (state)
         RST_VEC: begin
            mem_addr = {{(ADDR_W-1){1'b0}}, vec_sel};
            vec_rd   = 1'b1;
         end
         VEC_WAIT: begin
            mem_addr = {{(ADDR_W-1){1'b0}}, vec_sel};
         end
         RUN: begin
            fetch_valid = 1'b1;
         end
         default: begin
            mem_addr = {ADDR_W{1'b0}};
            vec_rd   = 1'b1;
         end
      endcase
      if (rst) begin
         mem_addr    = {ADDR_W{1'b0}};
         vec_rd      = 1'b1;
         fetch_valid = 1'b0;
      end
   end

   // PC, vector select, return address and interrupt bookkeeping. On a vector
   // decision the PC is left alone until VEC_WAIT loads the vector contents.
   // A request arriving in the accept cycle itself re-arms intr_pend.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= {ADDR_W{1'b0}};
         vec_sel   <= 1'b0;
         ret_addr  <= {ADDR_W{1'b0}};
         intr_pend <= 1'b0;
         intr_ack  <= 1'b0;
      end else begin
         intr_ack  <= accept;
         intr_pend <= intr | (intr_pend & ~accept);
         if (state == VEC_WAIT) begin
            pc <= mem_data;
         end else if (update_en && !mem_redirect && !accept) begin
            pc <= next_pc;
         end
         if (mem_redirect) begin
            vec_sel <= S_Target[0];
         end else if (accept) begin
            vec_sel <= 1'b1;
         end
         if (accept) begin
            ret_addr <= next_pc;
         end
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: a directed table of hand-computed vectors
// followed by randomized cycles compared against a cycle-level reference
// model that tracks "bubbles left before the vector lands" rather than states.

module tb_pc_sequencer;

   logic       clk;
   logic       rst;
   logic [1:0] S_Target;
   logic       E_Pc;
   logic       E_Imm;
   logic       load;
   logic       stall;
   logic       intr;
   logic [7:0] mem_data;
   logic [7:0] sp_data;
   logic [7:0] rb_data;
   logic [7:0] pc;
   logic [7:0] mem_addr;
   logic       vec_rd;
   logic       fetch_valid;
   logic       intr_ack;
   logic [7:0] ret_addr;

   int vectors;
   int miscompares;

   logic [7:0] mem [256];

   pc_sequencer #(.ADDR_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .S_Target    (S_Target),
      .E_Pc        (E_Pc),
      .E_Imm       (E_Imm),
      .load        (load),
      .stall       (stall),
      .intr        (intr),
      .mem_data    (mem_data),
      .sp_data     (sp_data),
      .rb_data     (rb_data),
      .pc          (pc),
      .mem_addr    (mem_addr),
      .vec_rd      (vec_rd),
      .fetch_valid (fetch_valid),
      .intr_ack    (intr_ack),
      .ret_addr    (ret_addr)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous instruction memory: data appears one cycle after the address.
   always @(posedge clk) begin
      mem_data <= mem[mem_addr];
   end

   typedef struct {
      logic       rst;
      logic [1:0] st;
      logic       epc;
      logic       imm;
      logic       ld;
      logic       stl;
      logic       irq;
      logic [7:0] sp;
      logic [7:0] rb;
      logic [7:0] e_pc;
      logic [7:0] e_addr;
      logic       e_vrd;
      logic       e_fv;
      logic       e_ack;
      logic [7:0] e_ret;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic [1:0] st, logic epc, logic imm,
                               logic ld, logic stl, logic irq,
                               logic [7:0] sp, logic [7:0] rb,
                               logic [7:0] e_pc, logic [7:0] e_addr,
                               logic e_vrd, logic e_fv, logic e_ack,
                               logic [7:0] e_ret);
      vec_t v;
      v.rst = r;    v.st = st;     v.epc = epc;     v.imm = imm;
      v.ld = ld;    v.stl = stl;   v.irq = irq;     v.sp = sp;
      v.rb = rb;    v.e_pc = e_pc; v.e_addr = e_addr;
      v.e_vrd = e_vrd; v.e_fv = e_fv; v.e_ack = e_ack; v.e_ret = e_ret;
      return v;
   endfunction

   // Drive one cycle's inputs on the falling edge.
   task automatic applyStimulus(input logic r, input logic [1:0] st,
                                input logic epc, input logic imm,
                                input logic ld, input logic stl,
                                input logic irq, input logic [7:0] sp,
                                input logic [7:0] rb);
      @(negedge clk);
      rst      = r;
      S_Target = st;
      E_Pc     = epc;
      E_Imm    = imm;
      load     = ld;
      stall    = stl;
      intr     = irq;
      sp_data  = sp;
      rb_data  = rb;
   endtask

   // Compare all observable outputs shortly after the rising edge.
   task automatic checkOutput(input string name, input logic [7:0] e_pc,
                              input logic [7:0] e_addr, input logic e_vrd,
                              input logic e_fv, input logic e_ack,
                              input logic [7:0] e_ret);
      bit bad;
      bad = 1'b0;
      vectors++;
      if (pc !== e_pc) begin
         $display("[TB] FAIL %s pc got %02h want %02h", name, pc, e_pc);
         bad = 1'b1;
      end
      if (mem_addr !== e_addr) begin
         $display("[TB] FAIL %s mem_addr got %02h want %02h", name, mem_addr, e_addr);
         bad = 1'b1;
      end
      if (vec_rd !== e_vrd) begin
         $display("[TB] FAIL %s vec_rd got %0b want %0b", name, vec_rd, e_vrd);
         bad = 1'b1;
      end
      if (fetch_valid !== e_fv) begin
         $display("[TB] FAIL %s fetch_valid got %0b want %0b", name, fetch_valid, e_fv);
         bad = 1'b1;
      end
      if (intr_ack !== e_ack) begin
         $display("[TB] FAIL %s intr_ack got %0b want %0b", name, intr_ack, e_ack);
         bad = 1'b1;
      end
      if (ret_addr !== e_ret) begin
         $display("[TB] FAIL %s ret_addr got %02h want %02h", name, ret_addr, e_ret);
         bad = 1'b1;
      end
      if (bad) miscompares++;
   endtask

   // Reference model: bubbles counts the vector-fetch cycles still to come
   // (2 = read being issued, 1 = waiting on data, 0 = fetching at pc).
   logic [7:0] m_pc;
   logic [7:0] m_ret;
   int         m_bub;
   logic       m_vec;
   logic       m_pend;
   logic       m_ack;

   task automatic modelStep();
      logic [7:0] tgt;
      logic       pend_next;
      if (rst) begin
         m_pc = 8'h00; m_ret = 8'h00; m_bub = 2; m_vec = 1'b0;
         m_pend = 1'b0; m_ack = 1'b0;
      end else begin
         pend_next = m_pend | intr;
         m_ack = 1'b0;
         if (m_bub == 2) begin
            m_bub = 1;
         end else if (m_bub == 1) begin
            m_pc  = mem[{7'd0, m_vec}];
            m_bub = 0;
         end else if (!stall && E_Pc) begin
            if (load)                tgt = m_pc + (E_Imm ? 8'd2 : 8'd1);
            else if (S_Target == 2)  tgt = sp_data;
            else                     tgt = rb_data;
            if (!load && S_Target < 2) begin
               m_vec = S_Target[0];
               m_bub = 2;
            end else if (m_pend) begin
               m_ret = tgt;
               m_ack = 1'b1;
               pend_next = intr;
               m_vec = 1'b1;
               m_bub = 2;
            end else begin
               m_pc = tgt;
            end
         end
         m_pend = pend_next;
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst = 1'b1; S_Target = 2'd0; E_Pc = 1'b0; E_Imm = 1'b0; load = 1'b1;
      stall = 1'b0; intr = 1'b0; sp_data = 8'h00; rb_data = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h10;
      mem[1] = 8'h80;

      //          rst st epc imm ld stl irq  sp     rb     pc     addr  vrd fv ack ret
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h00));
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h00));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h10, 8'h10, 0, 1, 0, 8'h00));
      tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 8'h00, 8'h00, 8'h11, 8'h11, 0, 1, 0, 8'h00));
      tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 8'h00, 8'h00, 8'h13, 8'h13, 0, 1, 0, 8'h00));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h13, 8'h13, 0, 1, 0, 8'h00));
      tbl.push_back(mk(0, 3, 1, 0, 0, 0, 0, 8'h00, 8'hFE, 8'hFE, 8'hFE, 0, 1, 0, 8'h00));
      tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h00));
      tbl.push_back(mk(0, 2, 1, 0, 0, 0, 0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 0, 1, 0, 8'h00));
      tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h00));
      tbl.push_back(mk(0, 3, 1, 0, 0, 0, 0, 8'h00, 8'h42, 8'h42, 8'h42, 0, 1, 0, 8'h00));
      tbl.push_back(mk(0, 2, 1, 0, 0, 0, 0, 8'h33, 8'h00, 8'h33, 8'h33, 0, 1, 0, 8'h00));
      tbl.push_back(mk(0, 3, 1, 0, 0, 0, 0, 8'h00, 8'h20, 8'h20, 8'h20, 0, 1, 0, 8'h00));
      tbl.push_back(mk(0, 0, 1, 0, 1, 1, 1, 8'h00, 8'h00, 8'h20, 8'h20, 0, 1, 0, 8'h00));
      tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 8'h00, 8'h00, 8'h20, 8'h20, 0, 1, 0, 8'h00));
      tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 8'h00, 8'h00, 8'h20, 8'h20, 0, 1, 0, 8'h00));
      tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 8'h00, 8'h00, 8'h20, 8'h01, 1, 0, 1, 8'h21));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h20, 8'h01, 0, 0, 0, 8'h21));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h80, 8'h80, 0, 1, 0, 8'h21));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 8'h00, 8'h00, 8'h80, 8'h01, 1, 0, 0, 8'h21));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h80, 8'h01, 0, 0, 0, 8'h21));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h80, 8'h80, 0, 1, 0, 8'h21));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h80, 8'h80, 0, 1, 0, 8'h21));
      tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 8'h00, 8'h00, 8'h80, 8'h01, 1, 0, 1, 8'h82));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 8'h00, 8'h00, 8'h80, 8'h01, 0, 0, 0, 8'h82));
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h00));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h10, 8'h10, 0, 1, 0, 8'h00));
      tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 8'h00, 8'h00, 8'h11, 8'h11, 0, 1, 0, 8'h00));

      $display("[TB] directed table: %0d rows", tbl.size());
      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i].rst, tbl[i].st, tbl[i].epc, tbl[i].imm,
                       tbl[i].ld, tbl[i].stl, tbl[i].irq, tbl[i].sp, tbl[i].rb);
         @(posedge clk);
         #1;
         checkOutput($sformatf("row%0d", i), tbl[i].e_pc, tbl[i].e_addr,
                     tbl[i].e_vrd, tbl[i].e_fv, tbl[i].e_ack, tbl[i].e_ret);
      end

      // Randomized phase: starts with a reset so the model is in step.
      $display("[TB] random phase");
      for (int i = 0; i < 600; i++) begin
         logic r;
         r = (i < 2) || ($urandom_range(0, 63) == 0);
         applyStimulus(r, 2'($urandom), ($urandom_range(0, 3) != 0),
                       1'($urandom), ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                       8'($urandom), 8'($urandom));
         modelStep();
         @(posedge clk);
         #1;
         checkOutput($sformatf("rand%0d", i), m_pc,
                     rst ? 8'h00 : (m_bub != 0 ? {7'd0, m_vec} : m_pc),
                     rst || (m_bub == 2), !rst && (m_bub == 0), m_ack, m_ret);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter register and next-PC datapath driven by the PC control unit's `S_Target`, `E_Pc`, `E_Imm` and `load` outputs. It holds the PC and computes PC+1, PC+2 or a redirect target. It runs the reset-vector fetch (M[0]) and the interrupt-vector fetch (M[1]) against the synchronous instruction memory. It sits in the fetch stage, between the control unit and instruction memory.

## Interface
- `ADDR_W`, 8, PC / memory address width; data words are also `ADDR_W` bits
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `S_Target`  in  2  target select: 0 M[0], 1 M[1], 2 X[SP], 3 R[rb]
- `E_Pc`  in  1  1: update PC this cycle; 0: hold
- `E_Imm`  in  1  0: increment by 1; 1: increment by 2; ignored when `load`=0 (may be X)
- `load`  in  1  0: load target; 1: increment
- `stall`  in  1  pipeline stall; freezes all state except `intr_pend`
- `intr`  in  1  interrupt request, level
- `mem_data`  in  ADDR_W  instruction memory read data, valid one cycle after `mem_addr`
- `sp_data`  in  ADDR_W  X[SP] value (popped return address)
- `rb_data`  in  ADDR_W  R[rb] value
- `pc`  out  ADDR_W  current PC (registered)
- `mem_addr`  out  ADDR_W  instruction memory address
- `vec_rd`  out  1  high while a vector read (M[0]/M[1]) is issued
- `fetch_valid`  out  1  high when `mem_addr`=`pc` is a real fetch; low inserts a bubble
- `intr_ack`  out  1  one-cycle pulse when an interrupt is accepted
- `ret_addr`  out  ADDR_W  return address saved at interrupt accept; the stack pushes it

## Operation
- FSM states: RST_VEC, VEC_WAIT, RUN.
- Register `vec_sel` selects the vector address: 0 = M[0], 1 = M[1].
- RST_VEC:
  - `mem_addr`=`vec_sel`, `vec_rd`=1, `fetch_valid`=0.
  - Next state VEC_WAIT, unconditionally (a stall does not hold it).
- VEC_WAIT:
  - `mem_addr`=`vec_sel`, `vec_rd`=0, `fetch_valid`=0.
  - `pc` <= `mem_data`; next state RUN.
- RUN:
  - `mem_addr`=`pc`, `fetch_valid`=1.
  - `stall`=1 or `E_Pc`=0: `pc` holds.
  - Otherwise `next`:
    - `load`=1: `pc`+1+`E_Imm`.
    - `load`=0, `S_Target`=2: `sp_data`.
    - `load`=0, `S_Target`=3: `rb_data`.
  - `load`=0 with `S_Target` 0 or 1: memory redirect. `vec_sel` <= `S_Target[0]`, next state RST_VEC, `pc` unchanged until VEC_WAIT loads it.
- Arithmetic is modulo 2^ADDR_W: 0xFF+1=0x00, 0xFE+2=0x00, 0xFF+2=0x01.
- Interrupts:
  - `intr_pend` sets whenever `intr`=1, including during a stall or a vector fetch.
  - It is accepted in RUN with `stall`=0, `E_Pc`=1 and no memory redirect in that cycle.
  - On accept: `ret_addr` <= `next` (post-branch PC), `intr_ack`=1, `intr_pend` cleared, `vec_sel` <= 1, next state RST_VEC.
  - A memory redirect has priority; the pending interrupt is taken at the first eligible RUN cycle after it.
- Reset:
  - State RST_VEC, `vec_sel`=0, `pc`=0, `ret_addr`=0, `intr_pend`=0.
  - Outputs while `rst`=1: `mem_addr`=0, `vec_rd`=1, `fetch_valid`=0, `intr_ack`=0.
  - Reset mid-vector-fetch or mid-RUN aborts immediately; no `intr_ack` is issued.

## Timing
- All state updates occur on the rising `clk` edge.
- `mem_addr`, `vec_rd` and `fetch_valid` are combinational from state and `pc`.
- `intr_ack` is registered and asserts in the first RST_VEC cycle after accept.
- Increment or register-target redirect takes effect the next cycle: zero bubbles.
- Vector fetch costs 2 cycles with `fetch_valid`=0 (RST_VEC, VEC_WAIT). `pc` equals the vector on the 3rd cycle after the decision edge, with `fetch_valid`=1.
- After reset release: 2 bubble cycles, then the first fetch at M[0] contents.
- `stall` in RST_VEC/VEC_WAIT is ignored; the memory read completes regardless.

## Test plan
- Reset release, M[0]=0x10: `vec_rd`=1 for one cycle at `mem_addr`=0, 2 bubbles, then `pc`=0x10 with `fetch_valid`=1.
- `pc`=0xFE with `load`=1, `E_Pc`=1, then `E_Imm`=1 -> `pc`=0x00. With `E_Imm`=0 from 0xFF -> 0x00. With `E_Pc`=0 -> `pc` holds.
- JZ taken (`load`=0, `S_Target`=3, `rb_data`=0x42) -> `pc`=0x42 next cycle. RET (`S_Target`=2, `sp_data`=0x33) -> `pc`=0x33.
- `pc`=0x20, `intr` pulsed during a 3-cycle stall, then `E_Pc`=1 and `load`=1 -> `intr_ack` pulse, `ret_addr`=0x21. With M[1]=0x80, `pc`=0x80 after 2 bubbles.
- `intr` and an M[1]-target redirect in the same cycle -> no `intr_ack`. Vector taken; interrupt accepted on the first eligible RUN cycle after it.
- `rst` asserted during VEC_WAIT -> next cycle `pc`=0, `vec_rd`=1, `mem_addr`=0, `intr_pend` cleared, no `intr_ack`.
